// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_unit
// Description : Single-outstanding instruction fetcher with static JAL
//               prediction, redirect flush and a prefetch FIFO of {pc, inst}.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_unit #(
    parameter int INST_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 17,
    parameter int BUF_DEPTH   = 4,
    parameter int RESET_PC    = 0,
    parameter int JAL_PREDICT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  icache_req_valid,
    output logic [ADDR_WIDTH-1:0] icache_req_addr,
    input  logic                  icache_resp_valid,
    input  logic [INST_WIDTH-1:0] icache_resp_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [INST_WIDTH-1:0] out_inst
);

    localparam int                c_PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [c_PTR_W:0]  c_DEPTH   = (c_PTR_W + 1)'(BUF_DEPTH);
    localparam logic [c_PTR_W:0]  c_CNT_ONE = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [6:0]        c_OP_JAL  = 7'b1101111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_DRAIN    = 2'd2
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [c_PTR_W-1:0]    r_head;
    logic [c_PTR_W-1:0]    r_tail;
    logic [c_PTR_W:0]      r_count;
    logic                  r_req_valid;
    logic [ADDR_WIDTH-1:0] r_mem_pc   [BUF_DEPTH];
    logic [INST_WIDTH-1:0] r_mem_inst [BUF_DEPTH];

    logic                  w_push;
    logic                  w_pop;
    logic                  w_is_jal;
    logic [20:0]           w_jal_imm;
    logic [ADDR_WIDTH-1:0] w_jal_off;
    logic [ADDR_WIDTH-1:0] w_next_pc;

    // A redirect cancels any push or pop happening in the same cycle.
    assign w_push = rdy && !redirect_valid && (r_state == ST_WAIT_MEM) && icache_resp_valid;
    assign w_pop  = rdy && !redirect_valid && (r_count != '0) && out_ready;

    assign w_is_jal  = (JAL_PREDICT != 0) && (icache_resp_data[6:0] == c_OP_JAL);
    assign w_jal_imm = {icache_resp_data[31], icache_resp_data[19:12],
                        icache_resp_data[20], icache_resp_data[30:21], 1'b0};
    assign w_jal_off = ADDR_WIDTH'($signed(w_jal_imm));
    assign w_next_pc = w_is_jal ? (r_fetch_pc + w_jal_off)
                                : (r_fetch_pc + ADDR_WIDTH'(4));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_fetch_pc  <= ADDR_WIDTH'(RESET_PC);
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_req_valid <= 1'b0;
        end else if (rdy) begin
            if (redirect_valid) begin
                r_fetch_pc  <= redirect_pc;
                r_head      <= '0;
                r_tail      <= '0;
                r_count     <= '0;
                r_req_valid <= 1'b0;
                // An outstanding request must still be drained unless its
                // response lands in this very cycle.
                case (r_state)
                    ST_WAIT_MEM,
                    ST_DRAIN:    r_state <= icache_resp_valid ? ST_IDLE : ST_DRAIN;
                    default:     r_state <= ST_IDLE;
                endcase
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_head <= r_head + c_PTR_ONE;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_CNT_ONE;
                    2'b01:   r_count <= r_count - c_CNT_ONE;
                    default: r_count <= r_count;
                endcase

                case (r_state)
                    ST_IDLE: begin
                        if (r_count < c_DEPTH) begin
                            r_state     <= ST_WAIT_MEM;
                            r_req_valid <= 1'b1;
                        end
                    end
                    ST_WAIT_MEM: begin
                        if (icache_resp_valid) begin
                            r_state     <= ST_IDLE;
                            r_req_valid <= 1'b0;
                            r_fetch_pc  <= w_next_pc;
                        end
                    end
                    ST_DRAIN: begin
                        if (icache_resp_valid) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state     <= ST_IDLE;
                        r_req_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Storage needs no reset: entries are only observed while counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_tail]   <= r_fetch_pc;
            r_mem_inst[r_tail] <= icache_resp_data;
        end
    end

    assign icache_req_valid = r_req_valid;
    assign icache_req_addr  = r_fetch_pc;
    assign out_valid        = (r_count != '0);
    assign out_pc           = r_mem_pc[r_head];
    assign out_inst         = r_mem_inst[r_head];

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_unit
// Description : Directed self-checking bench for inst_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

    localparam int          AW  = 17;
    localparam int          IW  = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rdy = 1'b1;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          resp_valid = 1'b0;
    logic [IW-1:0] resp_data = '0;
    logic          out_ready = 1'b0;

    logic          req_valid, nj_req_valid;
    logic [AW-1:0] req_addr, nj_req_addr;
    logic          out_valid, nj_out_valid;
    logic [AW-1:0] out_pc, nj_out_pc;
    logic [IW-1:0] out_inst, nj_out_inst;

    inst_fetch_unit #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .BUF_DEPTH(4),
                      .RESET_PC(0), .JAL_PREDICT(1)) u_dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .icache_req_valid(req_valid), .icache_req_addr(req_addr),
        .icache_resp_valid(resp_valid), .icache_resp_data(resp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst)
    );

    inst_fetch_unit #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .BUF_DEPTH(4),
                      .RESET_PC(0), .JAL_PREDICT(0)) u_dut_nj (
        .clk(clk), .rst(rst), .rdy(rdy),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .icache_req_valid(nj_req_valid), .icache_req_addr(nj_req_addr),
        .icache_resp_valid(resp_valid), .icache_resp_data(resp_data),
        .out_valid(nj_out_valid), .out_ready(out_ready),
        .out_pc(nj_out_pc), .out_inst(nj_out_inst)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Cache model: answers lat cycles after the request first appears.
    bit            auto_en = 1'b0;
    int            age = 0;
    int            lat = 2;
    logic [AW-1:0] jal_addr = '1;
    logic [31:0]   jal_word = NOP;
    logic          prev_req = 1'b0;

    task automatic cache_model();
        if (!auto_en) return;
        if (!rdy) begin
            resp_valid = 1'b0;
            return;
        end
        if (req_valid) begin
            age++;
            resp_valid = (age == lat);
            resp_data  = (req_addr == jal_addr) ? jal_word : NOP;
        end else begin
            age = 0;
            resp_valid = 1'b0;
        end
    endtask

    task automatic step();
        prev_req = req_valid;
        @(negedge clk);
        cache_model();
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; redirect_valid = 1'b0; resp_valid = 1'b0;
        out_ready = 1'b0; auto_en = 1'b0; age = 0; jal_addr = '1; jal_word = NOP;
        step();
        step();
        check("rst_req_valid", {31'd0, req_valid}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_addr", {15'd0, req_addr}, 32'd0);
        rst = 1'b0;
    endtask

    task automatic wait_issue(output logic [AW-1:0] a, output logic [AW-1:0] b);
        a = '1;
        b = '1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (req_valid && !prev_req) begin
                a = req_addr;
                b = nj_req_addr;
                return;
            end
        end
        check("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic collect_pops(input int n, input logic [AW-1:0] first);
        logic [AW-1:0] exp_pc;
        int            got;
        exp_pc = first;
        got    = 0;
        for (int k = 0; k < 80; k++) begin
            if (out_valid && out_ready) begin
                check("pop_pc", {15'd0, out_pc}, {15'd0, exp_pc});
                exp_pc = exp_pc + AW'(4);
                got++;
                if (got == n) return;
            end
            step();
        end
        check("pop_timeout", got, n);
    endtask

    logic [AW-1:0] a, b;
    logic          s_req, s_valid;
    logic [AW-1:0] s_addr, s_pc;
    int            issues;

    initial begin
        // 1: sequential fetch, first entry visible three cycles after reset
        do_reset();
        out_ready = 1'b1;
        auto_en   = 1'b1;
        step();
        check("t1_req_valid", {31'd0, req_valid}, 32'd1);
        check("t1_req_addr", {15'd0, req_addr}, 32'd0);
        check("t1_valid_c1", {31'd0, out_valid}, 32'd0);
        step();
        check("t1_valid_c2", {31'd0, out_valid}, 32'd0);
        step();
        check("t1_valid_c3", {31'd0, out_valid}, 32'd1);
        check("t1_inst", out_inst, NOP);
        collect_pops(4, AW'(0));

        // 2: backpressure stops fetch after four requests, then drains in order
        do_reset();
        auto_en = 1'b1;
        issues  = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (req_valid && !prev_req) issues++;
        end
        check("t2_issues", issues, 32'd4);
        check("t2_req_idle", {31'd0, req_valid}, 32'd0);
        check("t2_full_valid", {31'd0, out_valid}, 32'd1);
        check("t2_head_pc", {15'd0, out_pc}, 32'd0);
        out_ready = 1'b1;
        collect_pops(6, AW'(0));

        // 3: JAL at 0x10 with +0x100 offset
        do_reset();
        out_ready = 1'b1;
        auto_en   = 1'b1;
        jal_addr  = AW'(32'h10);
        jal_word  = 32'h1000_006F;
        for (int i = 1; i <= 6; i++) begin
            wait_issue(a, b);
            if (i == 5) check("t3_jal_fetch", {15'd0, a}, 32'h10);
            if (i == 6) begin
                check("t3_jal_target", {15'd0, a}, 32'h110);
                check("t3_nopredict", {15'd0, b}, 32'h14);
            end
        end

        // 4: redirect while waiting, stale response two cycles later
        do_reset();
        out_ready = 1'b1;
        step();
        check("t4_wait_req", {31'd0, req_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = AW'(32'h200);
        step();
        redirect_valid = 1'b0;
        check("t4_drain_req_a", {31'd0, req_valid}, 32'd0);
        step();
        check("t4_drain_req_b", {31'd0, req_valid}, 32'd0);
        resp_valid = 1'b1;
        resp_data  = NOP;
        step();
        resp_valid = 1'b0;
        check("t4_dropped", {31'd0, out_valid}, 32'd0);
        check("t4_req_after", {31'd0, req_valid}, 32'd0);
        step();
        check("t4_new_req", {31'd0, req_valid}, 32'd1);
        check("t4_new_addr", {15'd0, req_addr}, 32'h200);
        check("t4_fifo_empty", {31'd0, out_valid}, 32'd0);

        // 5: redirect coinciding with a response and a pop
        do_reset();
        step();
        resp_valid = 1'b1;
        resp_data  = NOP;
        step();
        resp_valid = 1'b0;
        check("t5_one_entry", {31'd0, out_valid}, 32'd1);
        step();
        check("t5_req_addr4", {15'd0, req_addr}, 32'h4);
        resp_valid     = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = AW'(32'h340);
        step();
        resp_valid     = 1'b0;
        redirect_valid = 1'b0;
        check("t5_flushed", {31'd0, out_valid}, 32'd0);
        check("t5_req_low", {31'd0, req_valid}, 32'd0);
        step();
        check("t5_new_req", {31'd0, req_valid}, 32'd1);
        check("t5_new_addr", {15'd0, req_addr}, 32'h340);
        check("t5_no_push", {31'd0, out_valid}, 32'd0);

        // 6: address wrap, then freeze mid-request with a lost response pulse
        do_reset();
        out_ready      = 1'b1;
        auto_en        = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = AW'(32'h1FFFC);
        step();
        redirect_valid = 1'b0;
        wait_issue(a, b);
        check("t6_top_addr", {15'd0, a}, 32'h1FFFC);
        wait_issue(a, b);
        check("t6_wrap_addr", {15'd0, a}, 32'h0);
        rdy     = 1'b0;
        auto_en = 1'b0;
        s_req = req_valid; s_addr = req_addr; s_valid = out_valid; s_pc = out_pc;
        resp_valid = 1'b1;
        resp_data  = NOP;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t6_hold_req", {31'd0, req_valid}, {31'd0, s_req});
            check("t6_hold_addr", {15'd0, req_addr}, {15'd0, s_addr});
            check("t6_hold_valid", {31'd0, out_valid}, {31'd0, s_valid});
            if (s_valid) check("t6_hold_pc", {15'd0, out_pc}, {15'd0, s_pc});
        end
        resp_valid = 1'b0;
        rdy        = 1'b1;
        auto_en    = 1'b1;
        collect_pops(1, AW'(0));
        wait_issue(a, b);
        check("t6_resume_addr", {15'd0, a}, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
